hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage processor.
- Drives stall/flush into the fetch-decode and decode-execute pipeline registers, including flush_E of the D/E register.
- Inserts load-use bubbles for a configurable memory latency and flushes wrong-path instructions after a taken branch for a configurable penalty.
- Produces combinational operand-forwarding selects for the execute stage.

---
 rtl/proc_pkg.sv | 16 +
 rtl/fwd_unit.sv | 33 +++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forwarding selects.
package proc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        BRFLUSH = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand-forwarding select for both execute-stage operands.
// Memory stage wins over writeback; register 0 is not special-cased.
module fwd_unit
    import proc_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] rA_E,
    input  logic [M-1:0] rB_E,
    input  logic [M-1:0] regScr_M,
    input  logic         regw_M,
    input  logic [M-1:0] regScr_W,
    input  logic         regw_W,
    output fwd_sel_t     fwdA_E,
    output fwd_sel_t     fwdB_E
);

    function automatic fwd_sel_t pick(input logic [M-1:0] src);
        if (regw_M && (regScr_M == src)) begin
            return FWD_M;
        end else if (regw_W && (regScr_W == src)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // Each operand is resolved independently.
    always_comb begin
        fwdA_E = pick(rA_E);
        fwdB_E = pick(rB_E);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and forwarding selects.
// Optional statistics counters are built when HZ_STATS_EN is defined.
module hazard_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned M      = 4,
    parameter int unsigned LD_LAT = 1,
    parameter int unsigned BR_PEN = 2,
    parameter int unsigned CW     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] rA_D,
    input  logic [M-1:0] rB_D,
    input  logic [M-1:0] rA_E,
    input  logic [M-1:0] rB_E,
    input  logic [M-1:0] regScr_E,
    input  logic         regw_E,
    input  logic         regmem_E,
    input  logic         brtaken_E,
    input  logic [M-1:0] regScr_M,
    input  logic         regw_M,
    input  logic [M-1:0] regScr_W,
    input  logic         regw_W,
    output logic         stall_F,
    output logic         stall_D,
    output logic         flush_D,
    output logic         flush_E,
    output logic [1:0]   fwdA_E,
    output logic [1:0]   fwdB_E,
    output logic         busy
`ifdef HZ_STATS_EN
    ,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
`endif
);

    localparam int unsigned MAXP = (LD_LAT > BR_PEN) ? LD_LAT : BR_PEN;
    localparam int unsigned CNTW = $clog2(MAXP) + 1;
    // First-cycle penalty is spent in RUN, so the counter starts two below the total.
    localparam logic [CNTW-1:0] LD_INIT = (LD_LAT > 1) ? CNTW'(LD_LAT - 2) : '0;
    localparam logic [CNTW-1:0] BR_INIT = (BR_PEN > 1) ? CNTW'(BR_PEN - 2) : '0;

    hz_state_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            br_accept;
    fwd_sel_t        fwd_a, fwd_b;

    assign load_use = regw_E && regmem_E && ((regScr_E == rA_D) || (regScr_E == rB_D));

    // State and bubble counter; reset aborts any pending sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and same-cycle stall/flush controls; all forced low while in reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        flush_D   = 1'b0;
        flush_E   = 1'b0;
        br_accept = 1'b0;
        if (rst) begin
            unique case (state_q)
                RUN: begin
                    if (brtaken_E) begin
                        br_accept = 1'b1;
                        flush_D   = 1'b1;
                        flush_E   = 1'b1;
                        if (BR_PEN > 1) begin
                            state_d = BRFLUSH;
                            cnt_d   = BR_INIT;
                        end
                    end else if (load_use) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                        if (LD_LAT > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = LD_INIT;
                        end
                    end
                end
                LDSTALL: begin
                    // E holds a bubble, so neither branch nor load-use can be seen here.
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                BRFLUSH: begin
                    flush_D = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    fwd_unit #(
        .M(M)
    ) u_fwd (
        .rA_E    (rA_E),
        .rB_E    (rB_E),
        .regScr_M(regScr_M),
        .regw_M  (regw_M),
        .regScr_W(regScr_W),
        .regw_W  (regw_W),
        .fwdA_E  (fwd_a),
        .fwdB_E  (fwd_b)
    );

    // Forwarding selects follow the inputs but read as regfile while in reset.
    always_comb begin
        fwdA_E = rst ? fwd_a : FWD_RF;
        fwdB_E = rst ? fwd_b : FWD_RF;
    end

    assign busy = (state_q != RUN);

`ifdef HZ_STATS_EN
    logic [CW-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_D && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CW'(1);
            end
            if (br_accept && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CW'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = br_accept ^ (CW != 0);
`endif

endmodule
